// File: rtl/mpeg_stream_fifo_if.sv
// MPEG byte-stream FIFO bus: write side, read side, status flags.
// No logic; timing is set by mpeg_stream_fifo (read data one cycle after mpeg_rd).
// Backpressure via mpeg_prog_full/mpeg_full; in_cnt/out_cnt exist only with MPEG_FIFO_CNT_EN.
interface mpeg_stream_fifo_if;
    logic [7:0]  mpeg_in;
    logic        mpeg_in_en;
    logic        stream_end;
    logic        mpeg_prog_full;
    logic        mpeg_full;
    logic        mpeg_rd;
    logic        mpeg_empty;
    logic [7:0]  mpeg_out;
    logic        mpeg_ready;
    logic        stream_done;
    logic        overflow;
    logic        underflow;
`ifdef MPEG_FIFO_CNT_EN
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;
`endif

    // FIFO side
    modport slave (
        input  mpeg_in, mpeg_in_en, stream_end, mpeg_rd,
        output mpeg_prog_full, mpeg_full, mpeg_empty, mpeg_out, mpeg_ready,
        output stream_done, overflow, underflow
`ifdef MPEG_FIFO_CNT_EN
        , output in_cnt, out_cnt
`endif
    );

    // Source/sink side
    modport master (
        output mpeg_in, mpeg_in_en, stream_end, mpeg_rd,
        input  mpeg_prog_full, mpeg_full, mpeg_empty, mpeg_out, mpeg_ready,
        input  stream_done, overflow, underflow
`ifdef MPEG_FIFO_CNT_EN
        , input in_cnt, out_cnt
`endif
    );
endinterface

// File: rtl/mpeg_stream_fifo.sv
// Single-clock byte FIFO with end-of-stream tracking; optional in/out counters under MPEG_FIFO_CNT_EN.
// Latency: write in N is readable from N+1; read accepted in N gives mpeg_out/mpeg_ready in N+1.
// Backpressure: mpeg_prog_full throttles the source; writes while full or after stream end are dropped (overflow).
module mpeg_stream_fifo #(
    parameter int DEPTH_LOG2       = 11,
    parameter int PROG_FULL_THRESH = 1536
) (
    input  logic              clk,
    input  logic              rst,
    mpeg_stream_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_THRESH = (DEPTH_LOG2+1)'(PROG_FULL_THRESH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  full, empty, wr_open, wr_acc, rd_acc;

    // Full/empty come from the registered level only, so there is no fall-through.
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign wr_open = (state == IDLE) || (state == STREAM);
    assign wr_acc  = bus.mpeg_in_en && !full && wr_open;
    assign rd_acc  = bus.mpeg_rd && !empty;

    assign bus.mpeg_full      = full;
    assign bus.mpeg_empty     = empty;
    assign bus.mpeg_prog_full = (level >= LVL_THRESH);
    assign bus.stream_done    = (state == DONE);

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.mpeg_in;
    end

    // Pointers and occupancy; simultaneous accept leaves level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Registered read data; mpeg_out holds between accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mpeg_out   <= 8'h00;
            bus.mpeg_ready <= 1'b0;
        end else begin
            bus.mpeg_ready <= rd_acc;
            if (rd_acc)
                bus.mpeg_out <= mem[rd_ptr];
        end
    end

    // Sticky error flags: dropped write, read while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.mpeg_in_en && !wr_acc)
                bus.overflow <= 1'b1;
            if (bus.mpeg_rd && empty)
                bus.underflow <= 1'b1;
        end
    end

    // End-of-stream FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: stream_end wins over the first write; DRAIN finishes once nothing is left to read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.stream_end)
                    state_nxt = DRAIN;
                else if (wr_acc)
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (bus.stream_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty && !rd_acc)
                    state_nxt = DONE;
            end
            default: state_nxt = DONE;
        endcase
    end

`ifdef MPEG_FIFO_CNT_EN
    // Accepted-transfer counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_cnt  <= '0;
            bus.out_cnt <= '0;
        end else begin
            if (wr_acc)
                bus.in_cnt <= bus.in_cnt + 32'd1;
            if (rd_acc)
                bus.out_cnt <= bus.out_cnt + 32'd1;
        end
    end
`endif
endmodule
